// File: rtl/countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : countdown_timer
// Purpose  : HH:MM:SS BCD countdown timer clocked by the 1-second clock.
//            Loads a value, decrements once per tick while running, and
//            raises Done on reaching 00:00:00 until acknowledged or
//            auto-cleared after AUTO_CLEAR ticks (0 = never auto-clear).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports    :
//   clk_1s          in   1-second clock, rising-edge active
//   reset           in   asynchronous, active-high reset
//   H_in1..S_in0    in   BCD load value (hour tens is 2 bits)
//   LD_timer        in   load the input digits
//   START           in   start / resume counting
//   PAUSE           in   freeze counting
//   STOP_al         in   acknowledge expiry or cancel a run
//   Done            out  high while expired
//   Running         out  high while counting
//   Load_err        out  one-tick pulse on a rejected load
//   H_out1..S_out0  out  current BCD count
// ============================================================================
module countdown_timer #(
  parameter int AUTO_CLEAR = 60,
  parameter int MAX_HOUR   = 23
) (
  input  logic       clk_1s,
  input  logic       reset,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  input  logic       LD_timer,
  input  logic       START,
  input  logic       PAUSE,
  input  logic       STOP_al,
  output logic       Done,
  output logic       Running,
  output logic       Load_err,
  output logic [1:0] H_out1,
  output logic [3:0] H_out0,
  output logic [3:0] M_out1,
  output logic [3:0] M_out0,
  output logic [3:0] S_out1,
  output logic [3:0] S_out0
);

  // Expiry counter only needs to reach AUTO_CLEAR-1; keep at least one bit.
  localparam int CW = (AUTO_CLEAR > 1) ? $clog2(AUTO_CLEAR + 1) : 1;
  localparam logic [CW-1:0] CLR_AT = CW'((AUTO_CLEAR > 0) ? AUTO_CLEAR - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [21:0]   cnt, cnt_nx, cnt_dec, din;
  logic [CW-1:0] exp_cnt, exp_cnt_nx;
  logic          load_err_nx;
  logic          load_ok;
  logic [6:0]    hour_val;
  logic          cnt_zero, cnt_one;

  // Digit order inside cnt: {H1, H0, M1, M0, S1, S0}
  assign din = {H_in1, H_in0, M_in1, M_in0, S_in1, S_in0};
  assign {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0} = cnt;

  assign cnt_zero = (cnt == 22'd0);
  assign cnt_one  = (cnt == 22'd1);

  assign hour_val = 7'(H_in1) * 7'd10 + 7'(H_in0);
  assign load_ok  = (int'(hour_val) <= MAX_HOUR) && (H_in0 <= 4'd9) &&
                    (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
                    (S_in1 <= 4'd5) && (S_in0 <= 4'd9);

  // BCD decrement with borrow ripple from seconds up to hour tens.
  always_comb begin
    logic [1:0] h1;
    logic [3:0] h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = cnt;
    if (s0 != 4'd0) begin
      s0 = s0 - 4'd1;
    end else begin
      s0 = 4'd9;
      if (s1 != 4'd0) begin
        s1 = s1 - 4'd1;
      end else begin
        s1 = 4'd5;
        if (m0 != 4'd0) begin
          m0 = m0 - 4'd1;
        end else begin
          m0 = 4'd9;
          if (m1 != 4'd0) begin
            m1 = m1 - 4'd1;
          end else begin
            m1 = 4'd5;
            if (h0 != 4'd0) begin
              h0 = h0 - 4'd1;
            end else begin
              h0 = 4'd9;
              h1 = h1 - 2'd1;
            end
          end
        end
      end
    end
    cnt_dec = {h1, h0, m1, m0, s1, s0};
  end

  // Next-state logic; input priority LD_timer > STOP_al > PAUSE > START.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    exp_cnt_nx  = exp_cnt;
    load_err_nx = 1'b0;

    if (LD_timer) begin
      if (load_ok) begin
        cnt_nx     = din;
        state_nx   = IDLE;
        exp_cnt_nx = '0;
      end else begin
        // Rejected load freezes everything for this tick.
        load_err_nx = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (!STOP_al && !PAUSE && START && !cnt_zero) begin
            state_nx = RUN;
          end
        end
        RUN: begin
          if (STOP_al) begin
            state_nx = IDLE;
          end else if (PAUSE) begin
            state_nx = PAUSED;
          end else if (cnt_zero) begin
            // Unreachable in normal use; avoids wrapping below zero.
            state_nx   = EXPIRED;
            exp_cnt_nx = '0;
          end else begin
            cnt_nx = cnt_dec;
            if (cnt_one) begin
              state_nx   = EXPIRED;
              exp_cnt_nx = '0;
            end
          end
        end
        PAUSED: begin
          if (STOP_al) begin
            state_nx = IDLE;
          end else if (!PAUSE && START) begin
            state_nx = RUN;
          end
        end
        EXPIRED: begin
          if (STOP_al) begin
            state_nx   = IDLE;
            exp_cnt_nx = '0;
          end else if ((AUTO_CLEAR > 0) && (exp_cnt == CLR_AT)) begin
            // Done has now been high for AUTO_CLEAR ticks.
            state_nx   = IDLE;
            exp_cnt_nx = '0;
          end else if (exp_cnt != '1) begin
            exp_cnt_nx = exp_cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Done/Running are registered copies of the next state so they change
  // on the same edge as the state itself.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      exp_cnt  <= '0;
      Load_err <= 1'b0;
      Done     <= 1'b0;
      Running  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      exp_cnt  <= exp_cnt_nx;
      Load_err <= load_err_nx;
      Done     <= (state_nx == EXPIRED);
      Running  <= (state_nx == RUN);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_timer
// Purpose  : Self-checking bench for countdown_timer: a table of directed
//            vectors followed by hand-written multi-cycle sequences for
//            expiry, acknowledge, auto-clear, long borrow runs and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_timer;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
  logic       LD_timer, START, PAUSE, STOP_al;
  logic       Done, Running, Load_err;
  logic [1:0] H_out1;
  logic [3:0] H_out0, M_out1, M_out0, S_out1, S_out0;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.AUTO_CLEAR(60), .MAX_HOUR(23)) dut (
    .clk_1s(clk_1s), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .S_in1(S_in1), .S_in0(S_in0),
    .LD_timer(LD_timer), .START(START), .PAUSE(PAUSE), .STOP_al(STOP_al),
    .Done(Done), .Running(Running), .Load_err(Load_err),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0)
  );

  always #5 clk_1s = ~clk_1s;

  typedef struct {
    logic        ld, st, pa, sp;
    logic [21:0] din;
    logic [21:0] dout;
    logic [2:0]  fl;   // {Done, Running, Load_err}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [21:0] bcd(int h, int m, int s);
    return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [21:0] secs(int t);
    return bcd(t / 3600, (t / 60) % 60, t % 60);
  endfunction

  function automatic vec_t mk(logic ld, logic st, logic pa, logic sp,
                              logic [21:0] din, logic [21:0] dout, logic [2:0] fl);
    vec_t v;
    v.ld = ld; v.st = st; v.pa = pa; v.sp = sp;
    v.din = din; v.dout = dout; v.fl = fl;
    return v;
  endfunction

  function automatic logic [21:0] dig();
    return {H_out1, H_out0, M_out1, M_out0, S_out1, S_out0};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic ld, logic st, logic pa, logic sp, logic [21:0] d);
    LD_timer = ld; START = st; PAUSE = pa; STOP_al = sp;
    {H_in1, H_in0, M_in1, M_in0, S_in1, S_in0} = d;
  endtask

  task automatic tick();
    @(posedge clk_1s);
    #1;
  endtask

  task automatic chk_all(string name, logic [21:0] d, logic [2:0] fl);
    chk({name, " digits"}, 32'(dig()), 32'(d));
    chk({name, " flags"}, 32'({Done, Running, Load_err}), 32'(fl));
  endtask

  initial begin
    int dh;

    // ---------------- vector table ----------------
    // ld st pa sp  din              dout             {Done,Run,Lerr}
    vecs.push_back(mk(1,0,0,0, bcd(0,0,3),   bcd(0,0,3),   3'b000));
    vecs.push_back(mk(0,1,0,0, 22'd0,        bcd(0,0,3),   3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,0,2),   3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,0,1),   3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,0,0),   3'b100));
    vecs.push_back(mk(0,0,0,1, 22'd0,        bcd(0,0,0),   3'b000));
    vecs.push_back(mk(0,1,0,0, 22'd0,        bcd(0,0,0),   3'b000));
    vecs.push_back(mk(1,0,0,0, bcd(12,34,56),bcd(12,34,56),3'b000));
    vecs.push_back(mk(1,0,0,0, bcd(0,0,60),  bcd(12,34,56),3'b001));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(12,34,56),3'b000));
    vecs.push_back(mk(1,0,0,0, bcd(24,0,0),  bcd(12,34,56),3'b001));
    vecs.push_back(mk(0,1,0,0, 22'd0,        bcd(12,34,56),3'b010));
    vecs.push_back(mk(1,0,0,0, bcd(24,0,0),  bcd(12,34,56),3'b011));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(12,34,55),3'b010));
    vecs.push_back(mk(1,0,0,0, bcd(23,59,59),bcd(23,59,59),3'b000));
    vecs.push_back(mk(1,0,0,0, bcd(0,60,0),  bcd(23,59,59),3'b001));
    vecs.push_back(mk(1,0,0,0, bcd(0,5,0),   bcd(0,5,0),   3'b000));
    vecs.push_back(mk(0,1,0,0, 22'd0,        bcd(0,5,0),   3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,4,59),  3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,4,58),  3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,4,57),  3'b010));
    vecs.push_back(mk(0,0,1,0, 22'd0,        bcd(0,4,57),  3'b000));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,0,0, 22'd0,      bcd(0,4,57),  3'b000));
    vecs.push_back(mk(0,1,1,0, 22'd0,        bcd(0,4,57),  3'b000));
    vecs.push_back(mk(0,1,0,0, 22'd0,        bcd(0,4,57),  3'b010));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,4,56),  3'b010));
    vecs.push_back(mk(0,1,1,0, 22'd0,        bcd(0,4,56),  3'b000));
    vecs.push_back(mk(0,0,0,1, 22'd0,        bcd(0,4,56),  3'b000));
    vecs.push_back(mk(0,1,0,0, 22'd0,        bcd(0,4,56),  3'b010));
    vecs.push_back(mk(0,0,0,1, 22'd0,        bcd(0,4,56),  3'b000));
    vecs.push_back(mk(0,0,0,0, 22'd0,        bcd(0,4,56),  3'b000));

    // ---------------- reset ----------------
    drive(0, 0, 0, 0, 22'd0);
    reset = 1'b1;
    tick();
    tick();
    chk_all("reset", 22'd0, 3'b000);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ld, vecs[i].st, vecs[i].pa, vecs[i].sp, vecs[i].din);
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].fl);
    end

    // ---------------- STOP_al at tick 5 of EXPIRED, START ignored ----------------
    drive(1, 0, 0, 0, bcd(0,0,2)); tick();
    drive(0, 1, 0, 0, 22'd0);      tick(); chk_all("ack start", bcd(0,0,2), 3'b010);
    drive(0, 0, 0, 0, 22'd0);      tick(); chk_all("ack run1", bcd(0,0,1), 3'b010);
    tick();                               chk_all("ack exp t1", 22'd0, 3'b100);
    tick();                               chk_all("ack exp t2", 22'd0, 3'b100);
    tick();                               chk_all("ack exp t3", 22'd0, 3'b100);
    drive(0, 1, 0, 0, 22'd0);      tick(); chk_all("ack exp t4 start", 22'd0, 3'b100);
    drive(0, 0, 0, 1, 22'd0);      tick(); chk_all("ack exp t5 stop", 22'd0, 3'b000);
    drive(0, 1, 0, 0, 22'd0);      tick(); chk_all("idle zero start", 22'd0, 3'b000);

    // ---------------- 01:00:00 full run with borrows, then auto-clear ----------------
    drive(1, 0, 0, 0, bcd(1,0,0)); tick(); chk_all("hr load", bcd(1,0,0), 3'b000);
    drive(0, 1, 0, 0, 22'd0);      tick(); chk_all("hr start", bcd(1,0,0), 3'b010);
    drive(0, 0, 0, 0, 22'd0);
    for (int t = 3599; t >= 0; t--) begin
      tick();
      chk($sformatf("hr t=%0d", t), 32'({dig(), Done, Running}),
          32'({secs(t), (t == 0), (t != 0)}));
    end
    dh = 1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (Done) dh++;
      else break;
    end
    chk("autoclear ticks", 32'(dh), 32'd60);
    chk_all("autoclear idle", 22'd0, 3'b000);

    // ---------------- LD_timer + STOP_al in EXPIRED, then reset in RUN ----------------
    drive(1, 0, 0, 0, bcd(0,0,1)); tick();
    drive(0, 1, 0, 0, 22'd0);      tick();
    drive(0, 0, 0, 0, 22'd0);      tick(); chk_all("ldstop exp", 22'd0, 3'b100);
    drive(1, 0, 0, 1, bcd(0,0,7)); tick(); chk_all("ldstop load", bcd(0,0,7), 3'b000);
    drive(0, 1, 0, 0, 22'd0);      tick(); chk_all("rst run", bcd(0,0,7), 3'b010);
    drive(0, 0, 0, 0, 22'd0);
    #2 reset = 1'b1;
    #1 chk_all("async reset", 22'd0, 3'b000);
    tick();
    reset = 1'b0;
    tick();                               chk_all("post reset", 22'd0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting companion to the alarm clock: loads an HH:MM:SS value as BCD digits and decrements it once per 1-second tick until it reaches 00:00:00.
- On expiry, raises Done, which holds until acknowledged or auto-cleared.
- Clocked by the 1-second clock that the clock block generates.
- Digit port format matches the clock block's digit outputs, so both can share display logic.

Parameters:
AUTO_CLEAR, 60, number of clk_1s ticks Done stays high in EXPIRED before it self-clears; 0 means it never self-clears.
MAX_HOUR, 23, largest hour value accepted at load.

Ports:
clk_1s  input  1  1-second clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
H_in1  input  2  load value, hour tens digit (BCD)
H_in0  input  4  load value, hour units digit
M_in1  input  4  load value, minute tens digit
M_in0  input  4  load value, minute units digit
S_in1  input  4  load value, second tens digit
S_in0  input  4  load value, second units digit
LD_timer  input  1  load the input digits into the counter
START  input  1  start or resume counting
PAUSE  input  1  freeze counting
STOP_al  input  1  acknowledge expiry, or cancel a run
Done  output  1  high while in EXPIRED
Running  output  1  high while in RUN
Load_err  output  1  one-tick pulse when a load is rejected
H_out1  output  2  current hour tens digit
H_out0  output  4  current hour units digit
M_out1  output  4  current minute tens digit
M_out0  output  4  current minute units digit
S_out1  output  4  current second tens digit
S_out0  output  4  current second units digit

Behaviour:
- Reset is asynchronous, active-high; clock is clk_1s.
- Reset values: all digits 0, state IDLE, Done=0, Running=0, Load_err=0, expiry counter 0.
- All outputs are registered.
- States: IDLE, RUN, PAUSED, EXPIRED.
- Input priority on each edge: reset > LD_timer > STOP_al > PAUSE > START.
- Load validity: a load is valid iff H_in1*10+H_in0 <= MAX_HOUR, H_in0<=9, M_in1<=5, M_in0<=9, S_in1<=5, S_in0<=9.
- LD_timer, any state, valid load: digits take the input values; next state IDLE; Done=0.
- LD_timer, any state, invalid load: digits and state unchanged; Load_err=1 for exactly that tick.
- Load_err is 0 on every other tick.
- IDLE:
  - START with count != 0 -> RUN. No decrement on the START edge; the first decrement happens on the next edge.
  - START with count == 0 -> stay in IDLE.
- RUN: decrement by 1 on each edge, BCD borrow chain:
  - S0: 0 -> 9 and borrow into S1; S1: 0 -> 5 and borrow into M0.
  - M0: 0 -> 9 and borrow into M1; M1: 0 -> 5 and borrow into H0.
  - H0: 0 -> 9 and borrow into H1.
  - Outputs never show invalid BCD.
- RUN, count reaching zero: on the edge where the count goes 00:00:01 -> 00:00:00, next state is EXPIRED; Done=1 and Running=0 on that same edge.
- RUN, PAUSE=1: -> PAUSED; the count does not decrement on that edge.
- RUN, STOP_al=1: -> IDLE (cancel); the count is retained and not decremented.
- PAUSED:
  - START -> RUN; the next decrement happens one edge later.
  - STOP_al -> IDLE.
  - Count is held.
  - If PAUSE and START are both high, PAUSE wins and the block stays in PAUSED.
- EXPIRED:
  - Digits stay at 00:00:00.
  - STOP_al=1 -> IDLE, Done=0 on that edge.
  - START is ignored.
  - Expiry counter increments each tick. With AUTO_CLEAR > 0, once Done has been high for AUTO_CLEAR ticks the block goes to IDLE and Done=0.
  - The expiry counter clears on entry to EXPIRED.
- Running = (state==RUN); Done = (state==EXPIRED).
- Reset mid-operation: immediate return to reset values, whatever the state.

Test Plan:
- Reset, then load 00:00:03, then START: Running=1 one tick later; outputs 00:00:02, :01, :00 on successive ticks; Done=1 on the :00 tick; Running=0 on that tick.
- Load 01:00:00, START, run 1 tick past the start edge -> outputs 00:59:59; let it run to expiry and check the 00:10:00 -> 00:09:59 and 00:00:10 -> 00:00:09 borrows.
- Load 00:05:00, START, after 3 decrements assert PAUSE -> count holds at 00:04:57 for 5 ticks; START -> 00:04:56 one tick after the resume edge.
- Load with S_in1=6, and separately with hour 24 -> Load_err pulses one tick; digits and state unchanged. Load 23:59:59 -> accepted.
- Expire with AUTO_CLEAR=60 and STOP_al held low -> Done is high for exactly 60 ticks, then IDLE. Repeat with STOP_al at tick 5 of EXPIRED -> Done=0 on that edge.
- Assert reset while in RUN at 00:00:07 -> all digits 0, Done=0, Running=0 immediately. Assert LD_timer and STOP_al together in EXPIRED -> load takes effect and Done=0.
